// File: rtl/sum_diff_checker.sv
// ----------------------------------------------------------------------------
// sum_diff_checker
//
// Response monitor for the adder / subtractor / comparator datapath. Each
// accepted handshake carries one stimulus vector (a, b, c, d) together with
// the outputs the datapath produced for it (ab_obs, cd_obs, altb_obs). The
// checker recomputes the expected results, scores the vector and keeps
// pass/fail counters plus the index of the first failing vector in the run.
//
// Optional feature (compile-time macro):
//   STOP_ON_FAIL_EN  - when defined, the first failing vector ends the run:
//                      the checker stops accepting, scores whatever is still
//                      in flight and goes to DONE without waiting for in_last.
//                      When undefined, a run always continues until in_last.
//
// Ports:
//   clock             single clock, all state on the rising edge
//   reset             synchronous, active-high
//   start             one-cycle pulse; clears scores and begins a run
//                     (honoured only when idle or finished)
//   in_valid          a vector is present on a .. altb_obs
//   in_ready          checker accepts a vector this cycle
//   in_last           marks the accepted vector as the final one of the run
//   a, b, c, d        stimulus operands (WIDTH bits)
//   ab_obs, cd_obs    observed sum a+b and difference c-d (WIDTH bits)
//   altb_obs          observed comparator output (ab < cd)
//   mismatch          one-cycle pulse per failing vector
//   pass_count        saturating count of passing vectors
//   fail_count        saturating count of failing vectors
//   first_fail_valid  a failure has been captured in this run
//   first_fail_idx    0-based index of the first failing vector
//   busy              run in progress (RUN or DRAIN)
//   finished          run complete, results held (DONE)
//
// Pipeline: a vector accepted in cycle N sits in the input stage during
// N+1, where it is compared; the score (counters, mismatch, first-failure
// capture) becomes visible in cycle N+2.
// ----------------------------------------------------------------------------
module sum_diff_checker #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] ab_obs,
   input  logic [WIDTH-1:0] cd_obs,
   input  logic             altb_obs,
   output logic             mismatch,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             first_fail_valid,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic             busy,
   output logic             finished
);

   // Saturation ceiling shared by every counter.
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Run-control states.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;

   // Input stage: the accepted vector and its index within the run.
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] s1_c;
   logic [WIDTH-1:0] s1_d;
   logic [WIDTH-1:0] s1_ab;
   logic [WIDTH-1:0] s1_cd;
   logic             s1_altb;
   logic [CNT_W-1:0] s1_idx;

   // Index that the next accepted vector will carry.
   logic [CNT_W-1:0] vec_idx;

   logic             accept_c;
   logic             clear_c;
   logic [WIDTH-1:0] ab_exp_c;
   logic [WIDTH-1:0] cd_exp_c;
   logic             altb_exp_c;
   logic             fail_c;
   logic             pass_c;
   logic             stop_c;

   assign accept_c = in_valid & in_ready;

   // start only takes effect when no run is in progress.
   assign clear_c = start & ((state == ST_IDLE) | (state == ST_DONE));

   // Expected results: sum and difference wrap modulo 2^WIDTH because the
   // operands and results share the same width; compare is unsigned.
   assign ab_exp_c   = s1_a + s1_b;
   assign cd_exp_c   = s1_c - s1_d;
   assign altb_exp_c = (ab_exp_c < cd_exp_c);

   assign fail_c = s1_valid & ((s1_ab   != ab_exp_c) |
                               (s1_cd   != cd_exp_c) |
                               (s1_altb != altb_exp_c));
   assign pass_c = s1_valid & ~fail_c;

`ifdef STOP_ON_FAIL_EN
   // Any failure seen while running ends the run early.
   assign stop_c = fail_c;
`else
   assign stop_c = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if ((accept_c & in_last) | stop_c) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The score stage empties this cycle once nothing is left in
            // the input stage, so DONE follows the last visible update.
            if (!s1_valid) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Status outputs registered from the next state so they track the state
   // register cycle for cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         in_ready <= 1'b0;
         busy     <= 1'b0;
         finished <= 1'b0;
      end else begin
         in_ready <= (state_nxt == ST_RUN);
         busy     <= (state_nxt == ST_RUN) | (state_nxt == ST_DRAIN);
         finished <= (state_nxt == ST_DONE);
      end
   end

   // Input-stage payload; only meaningful while s1_valid is set.
   always_ff @(posedge clock) begin
      if (accept_c) begin
         s1_a    <= a;
         s1_b    <= b;
         s1_c    <= c;
         s1_d    <= d;
         s1_ab   <= ab_obs;
         s1_cd   <= cd_obs;
         s1_altb <= altb_obs;
         s1_idx  <= vec_idx;
      end
   end

   // Pipeline occupancy and vector index.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         vec_idx  <= '0;
      end else begin
         s1_valid <= accept_c;
         if (clear_c) begin
            vec_idx <= '0;
         end else if (accept_c && (vec_idx != CNT_MAX)) begin
            vec_idx <= vec_idx + CNT_ONE;
         end
      end
   end

   // Score stage: mismatch pulse, saturating counters, first-failure capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         mismatch         <= 1'b0;
         pass_count       <= '0;
         fail_count       <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else begin
         mismatch <= fail_c;
         if (clear_c) begin
            pass_count       <= '0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
         end else begin
            if (pass_c && (pass_count != CNT_MAX)) begin
               pass_count <= pass_count + CNT_ONE;
            end
            if (fail_c && (fail_count != CNT_MAX)) begin
               fail_count <= fail_count + CNT_ONE;
            end
            // Only the first failure of a run is recorded.
            if (fail_c && !first_fail_valid) begin
               first_fail_valid <= 1'b1;
               first_fail_idx   <= s1_idx;
            end
         end
      end
   end

endmodule

// File: doc/sum_diff_checker.md
# sum_diff_checker

Self-checking response monitor for the adder/subtractor/comparator datapath: consumes one stimulus vector (a, b, c, d) plus the observed datapath outputs (a+b, c-d, compare result) per handshake, recomputes the expected values and scores the result. It is the receiving end of the stimulus driver that exercises the Adder, Subtractor and Comparator units, and replaces eyeball checking of monitor output with pass/fail counters and first-failure capture.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits
- CNT_W, 8, width of pass/fail/index counters

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; clears scores and begins a test run
- in_valid  in  1  vector present on a..altb_obs
- in_ready  out  1  checker accepts a vector this cycle
- in_last  in  1  qualifies the accepted vector as final of the run
- a, b, c, d  in  WIDTH  stimulus operands
- ab_obs, cd_obs  in  WIDTH  observed sum and difference
- altb_obs  in  1  observed comparator output
- mismatch  out  1  one-cycle pulse per failing vector
- pass_count, fail_count  out  CNT_W  scored vector counts
- first_fail_valid  out  1  a failure has been captured this run
- first_fail_idx  out  CNT_W  0-based index of first failing vector
- busy  out  1  state is RUN or DRAIN
- finished  out  1  state is DONE

## Operation
- Expected: ab_exp = (a+b) mod 2^WIDTH; cd_exp = (c-d) mod 2^WIDTH (two's-complement wrap); altb_exp = (ab_exp < cd_exp), unsigned compare on WIDTH bits.
- Vector fails if any of ab_obs≠ab_exp, cd_obs≠cd_exp, altb_obs≠altb_exp; else passes.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE: in_ready=0; start -> RUN.
  - RUN: in_ready=1; accepted vector with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0; when both pipeline stages empty -> DONE.
  - DONE: in_ready=0; results held; start -> RUN.
- start in RUN or DRAIN is ignored.
- Entering RUN from start clears pass_count, fail_count, first_fail_valid, first_fail_idx and the vector index counter.
- Accept = in_valid & in_ready; each accept increments the vector index (saturates at 2^CNT_W-1).
- pass_count/fail_count saturate at 2^CNT_W-1; saturation never wraps.
- first_fail_idx captured only on first failure of the run (first_fail_valid 0->1); later failures do not overwrite.

## Timing
- Reset: state IDLE; in_ready=0, mismatch=0, pass_count=0, fail_count=0, first_fail_valid=0, first_fail_idx=0, busy=0, finished=0; pipeline valid bits cleared.
- Two-stage pipeline: cycle N accept registers inputs; cycle N+1 computes and compares; counters, mismatch and first_fail_* update visible at N+2.
- Back-to-back accepts every cycle supported; no bubbles required.
- DRAIN lasts exactly 2 cycles after the in_last accept; finished asserts the cycle after the last score update is visible.
- Reset mid-run discards in-flight vectors with no counter update.
- in_valid while in_ready=0: ignored, no side effects.

## Configuration
- STOP_ON_FAIL_EN defined: first failure forces RUN -> DRAIN (in_ready drops the cycle mismatch pulses); vectors already in flight are still scored; run ends in DONE without in_last.
- Not defined: run continues until in_last regardless of failures.

## Test plan
- Reset then idle: all outputs at reset values; in_valid=1 with no start -> in_ready=0, counters stay 0.
- start; vectors (a,b,c,d,ab,cd,altb) = (9,4,9,4,13,5,0), (9,4,0,4,13,12,0), (9,4,0,1,13,15,1) back-to-back, last flagged -> pass_count=3, fail_count=0, finished=1 two cycles after last score.
- Vector (9,4,9,6,13,3,1) at index 1 of 3 -> mismatch pulses once at accept+2, fail_count=1, first_fail_idx=1; second failure at index 2 leaves first_fail_idx=1.
- Wrap: a=15,b=1,ab=0; c=0,d=1,cd=15,altb=1 -> pass; same with ab=16-truncated wrong value 1 -> fail.
- CNT_W=2: 5 passing vectors -> pass_count saturates at 3.
- Reset asserted one cycle after an accept -> no counter change; with STOP_ON_FAIL_EN, failure at index 0 of a continuous stream -> in_ready low after mismatch, finished=1, pass_count counts in-flight passers only.
